arcino_rf_wb_ctrl: RTL

- Write-back controller and scoreboard in front of the single-write-port ARCINO register file.
- Arbitrates the one RF write port between the ALU write-back path and the LSU load-return path.
- Tracks destination registers of outstanding loads and flags read-after-write hazards to decode for operands A and B.
- Drives the RF write port from registered outputs.

---
 rtl/arcino_rf_wb_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/arcino_rf_wb_ctrl.sv
// ARCINO register-file write-back controller.
// Arbitrates the single RF write port between ALU write-back and LSU load
// return (LSU has fixed priority), keeps a pending-load scoreboard and flags
// operand hazards to decode. The RF write port is driven from flops.
// Optional feature: define ARCINO_RF_SCRUB_EN to zero every register
// 1..NUM_WORDS-1 after reset release before normal operation starts.
module arcino_rf_wb_ctrl #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alu_req_i,
  input  logic [4:0]           alu_waddr_i,
  input  logic [DataWidth-1:0] alu_wdata_i,
  output logic                 alu_gnt_o,
  input  logic                 lsu_req_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_gnt_o,
  input  logic                 load_issue_i,
  input  logic [4:0]           load_issue_addr_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 busy_o
);

  localparam int unsigned AddrWidth = RV32E ? 4 : 5;
  localparam int unsigned NumWords  = 1 << AddrWidth;

  typedef enum logic [0:0] {
    ST_SCRUB = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

`ifdef ARCINO_RF_SCRUB_EN
  localparam state_e RstState = ST_SCRUB;
`else
  localparam state_e RstState = ST_RUN;
`endif

  state_e                 state_q, state_d;
  logic                   run_s;
  logic                   busy_s;
  logic                   alu_gnt_s;
  logic                   lsu_gnt_s;
  logic [NumWords-1:0]    pending_q, pending_d;
  logic                   rf_we_q, rf_we_d;
  logic [4:0]             rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0]   rf_wdata_q, rf_wdata_d;
  logic [AddrWidth-1:0]   lsu_idx_s;
  logic [AddrWidth-1:0]   alu_idx_s;
  logic [AddrWidth-1:0]   load_idx_s;
  logic [AddrWidth-1:0]   ra_idx_s;
  logic [AddrWidth-1:0]   rb_idx_s;
  logic [AddrWidth-1:0]   wr_idx_s;
  logic                   hazard_a_s;
  logic                   hazard_b_s;

  // Only the low address bits identify a register in the selected RF size.
  assign lsu_idx_s  = lsu_waddr_i[AddrWidth-1:0];
  assign alu_idx_s  = alu_waddr_i[AddrWidth-1:0];
  assign load_idx_s = load_issue_addr_i[AddrWidth-1:0];
  assign ra_idx_s   = raddr_a_i[AddrWidth-1:0];
  assign rb_idx_s   = raddr_b_i[AddrWidth-1:0];
  assign wr_idx_s   = rf_waddr_q[AddrWidth-1:0];

`ifdef ARCINO_RF_SCRUB_EN
  localparam logic [AddrWidth-1:0] ScrubLast = {AddrWidth{1'b1}};
  localparam logic [AddrWidth-1:0] ScrubOne  = {{(AddrWidth-1){1'b0}}, 1'b1};

  logic [AddrWidth-1:0] scrub_cnt_q, scrub_cnt_d;

  // Scrub address counter: walks 1..NUM_WORDS-1 while in SCRUB.
  always_comb begin
    scrub_cnt_d = scrub_cnt_q;
    if ((state_q == ST_SCRUB) && (scrub_cnt_q != ScrubLast)) begin
      scrub_cnt_d = scrub_cnt_q + ScrubOne;
    end else begin
      scrub_cnt_d = scrub_cnt_q;
    end
  end

  // Scrub counter register; reset restarts the scrub at address 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scrub_cnt_q <= ScrubOne;
    end else begin
      scrub_cnt_q <= scrub_cnt_d;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RstState;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: SCRUB leaves after the last scrub address, RUN is terminal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SCRUB: begin
`ifdef ARCINO_RF_SCRUB_EN
        if (scrub_cnt_q == ScrubLast) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SCRUB;
        end
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs: grants only in RUN, LSU wins because responses cannot stall.
  always_comb begin
    run_s     = 1'b0;
    busy_s    = 1'b0;
    alu_gnt_s = 1'b0;
    lsu_gnt_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        run_s     = 1'b1;
        busy_s    = 1'b0;
        lsu_gnt_s = lsu_req_i;
        alu_gnt_s = alu_req_i & ~lsu_req_i;
      end
      ST_SCRUB: begin
        run_s  = 1'b0;
        busy_s = 1'b1;
      end
      default: begin
        run_s  = 1'b0;
        busy_s = 1'b1;
      end
    endcase
  end

  // Write path: capture the granted request (or scrub word) for next cycle.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (!run_s) begin
`ifdef ARCINO_RF_SCRUB_EN
      rf_we_d    = 1'b1;
      rf_waddr_d = 5'(scrub_cnt_q);
      rf_wdata_d = {DataWidth{1'b0}};
`else
      rf_we_d    = 1'b0;
`endif
    end else if (lsu_gnt_s) begin
      rf_we_d    = (lsu_idx_s != {AddrWidth{1'b0}});
      rf_waddr_d = lsu_waddr_i;
      rf_wdata_d = lsu_wdata_i;
    end else if (alu_gnt_s) begin
      rf_we_d    = (alu_idx_s != {AddrWidth{1'b0}});
      rf_waddr_d = alu_waddr_i;
      rf_wdata_d = alu_wdata_i;
    end else begin
      rf_we_d    = 1'b0;
    end
  end

  // Scoreboard update: clear on LSU return, then set on load issue so a
  // newer load to the same register keeps it pending. x0 never pends.
  always_comb begin
    pending_d = pending_q;
    if (lsu_gnt_s) begin
      pending_d[lsu_idx_s] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (run_s && load_issue_i) begin
      pending_d[load_idx_s] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  // Write-port and scoreboard registers; reset drops any write in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= {DataWidth{1'b0}};
      pending_q  <= {NumWords{1'b0}};
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

  // Hazards: pending load or a write still travelling into the RF.
  always_comb begin
    hazard_a_s = pending_q[ra_idx_s] |
                 (rf_we_q & (wr_idx_s == ra_idx_s) & (ra_idx_s != {AddrWidth{1'b0}}));
    hazard_b_s = pending_q[rb_idx_s] |
                 (rf_we_q & (wr_idx_s == rb_idx_s) & (rb_idx_s != {AddrWidth{1'b0}}));
  end

  assign alu_gnt_o  = alu_gnt_s;
  assign lsu_gnt_o  = lsu_gnt_s;
  assign hazard_a_o = hazard_a_s;
  assign hazard_b_o = hazard_b_s;
  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
`ifdef ARCINO_RF_SCRUB_EN
  assign busy_o     = busy_s;
`else
  assign busy_o     = 1'b0;
`endif

endmodule
